// File: rtl/result_packer.sv
// Write-back packer: pairs PE results into words (low half first), tags each
// row's final word, and queues the words for the AXI write side.
module result_packer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [4:0]                row_len,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic                      out_last,
  output logic                      row_done,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int unsigned WW = 2 * DATA_WIDTH;
  localparam int unsigned EW = WW + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_LOW,
    ST_HIGH
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] half_q, half_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            len_q, len_d;
  logic [5:0]            cur_len;
  logic                  rdy_en_q;
  logic                  row_done_q;
  logic [CW-1:0]         count_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         head;

  logic                  full, empty, accept, pop;
  logic                  push, push_last, row_end;
  logic [WW-1:0]         push_word;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign in_rdy = rdy_en_q && !full;
  assign accept = in_vld && in_rdy;
  assign pop    = !empty && out_rdy;

  // Packer next-state: row length is latched from the live input on a row's first element.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    cur_len   = len_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_word = '0;
    row_end   = 1'b0;
    if (cnt_q == 6'd0) begin
      cur_len = (row_len == 5'd0) ? 6'd32 : {1'b0, row_len};
    end
    if (accept) begin
      len_d   = cur_len;
      row_end = ((cnt_q + 6'd1) == cur_len);
      cnt_d   = row_end ? 6'd0 : cnt_q + 6'd1;
      case (state_q)
        ST_LOW: begin
          if (row_end) begin
            push      = 1'b1;
            push_last = 1'b1;
            push_word = {{DATA_WIDTH{1'b0}}, data_in};
          end else begin
            half_d  = data_in;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          push      = 1'b1;
          push_last = row_end;
          push_word = {data_in, half_q};
          state_d   = ST_LOW;
        end
        default: state_d = ST_LOW;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOW;
      half_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      rdy_en_q   <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      rdy_en_q   <= 1'b1;
      row_done_q <= accept && row_end;
    end
  end

  // FIFO bookkeeping; push can never meet a full FIFO because accept requires !full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {push_last, push_word};
  end

  assign head       = mem[rd_ptr_q];
  assign out_vld    = !empty;
  assign out_data   = empty ? '0 : head[WW-1:0];
  assign out_last   = !empty && head[WW];
  assign row_done   = row_done_q;
  assign fill_level = count_q;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: packing, padding, last tagging,
// back-pressure, steady streaming and reset mid-row.
module tb_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [15:0] data_in;
  logic [4:0]  row_len;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        out_last;
  logic        row_done;
  logic [3:0]  fill_level;

  int tests  = 0;
  int fails  = 0;
  int rd_cnt = 0;

  result_packer #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .data_in    (data_in),
    .row_len    (row_len),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_last   (out_last),
    .row_done   (row_done),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  // Count row_done pulses just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (row_done) rd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one element at a falling edge and hold it until accepted.
  task automatic send(input logic [15:0] d);
    int   n;
    logic acc;
    n       = 0;
    in_vld  = 1'b1;
    data_in = d;
    do begin
      acc = in_rdy;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    in_vld = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  // Wait for a head word, compare it, then pop it with a one-cycle out_rdy.
  task automatic pop_word(input string tag, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    while (!out_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 32'(out_vld), 32'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_last"}, 32'(out_last), 32'(l));
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  function automatic logic [31:0] pair(input logic [15:0] base, input int k);
    logic [15:0] lo, hi;
    lo = 16'(base + 16'(2 * k - 1));
    hi = 16'(base + 16'(2 * k));
    return {hi, lo};
  endfunction

  int exp_fill [6] = '{4, 3, 3, 2, 2, 1};

  initial begin
    rst     = 1'b1;
    in_vld  = 1'b0;
    data_in = '0;
    row_len = '0;
    out_rdy = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);

    // Row of 4; a mid-row row_len change must be ignored
    row_len = 5'd4;
    send(16'h0001);
    row_len = 5'd7;
    send(16'h0002);
    send(16'h0003);
    send(16'h0004);
    chk("t1_row_done", 32'(row_done), 32'd1);
    pop_word("t1_w0", 32'h0002_0001, 1'b0);
    pop_word("t1_w1", 32'h0004_0003, 1'b1);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd1);

    // Odd row of 3: final element zero-padded
    row_len = 5'd3;
    send(16'hAAAA);
    send(16'hBBBB);
    send(16'hCCCC);
    pop_word("t2_w0", 32'hBBBB_AAAA, 1'b0);
    pop_word("t2_w1", 32'h0000_CCCC, 1'b1);
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd2);

    // Rows of 1, back to back
    row_len = 5'd1;
    send(16'h0011);
    chk("t3_latency_vld", 32'(out_vld), 32'd1);
    send(16'h0022);
    send(16'h0033);
    pop_word("t3_w0", 32'h0000_0011, 1'b1);
    pop_word("t3_w1", 32'h0000_0022, 1'b1);
    pop_word("t3_w2", 32'h0000_0033, 1'b1);
    chk("t3_rd_cnt", 32'(rd_cnt), 32'd5);

    // Row of 32 with the FIFO filled to full
    row_len = 5'd0;
    for (int i = 1; i <= 16; i++) send(16'(16'h0100 + 16'(i)));
    chk("t4_full_fill", 32'(fill_level), 32'd8);
    chk("t4_full_in_rdy", 32'(in_rdy), 32'd0);
    in_vld  = 1'b1;
    data_in = 16'h0111;
    repeat (3) @(negedge clk);
    chk("t4_stall_fill", 32'(fill_level), 32'd8);
    in_vld = 1'b0;
    pop_word("t4_a1", pair(16'h0100, 1), 1'b0);
    chk("t4_in_rdy_back", 32'(in_rdy), 32'd1);
    for (int k = 2; k <= 8; k++) pop_word("t4_a", pair(16'h0100, k), 1'b0);
    chk("t4_mid_rd_cnt", 32'(rd_cnt), 32'd5);
    for (int i = 17; i <= 32; i++) send(16'(16'h0100 + 16'(i)));
    for (int k = 9; k <= 15; k++) pop_word("t4_b", pair(16'h0100, k), 1'b0);
    pop_word("t4_b16", pair(16'h0100, 16), 1'b1);
    chk("t4_rd_cnt", 32'(rd_cnt), 32'd6);

    // Steady stream: one pop per cycle, push every other cycle
    row_len = 5'd0;
    for (int i = 1; i <= 8; i++) send(16'(16'h0200 + 16'(i)));
    chk("t5_fill_start", 32'(fill_level), 32'd4);
    out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_vld  = 1'b1;
      data_in = 16'(16'h0209 + 16'(c));
      chk("t5_fill", 32'(fill_level), 32'(exp_fill[c]));
      chk("t5_data", out_data, pair(16'h0200, c + 1));
      chk("t5_in_rdy", 32'(in_rdy), 32'd1);
      @(negedge clk);
    end
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    chk("t5_fill_end", 32'(fill_level), 32'd1);
    chk("t5_tail", out_data, pair(16'h0200, 7));

    // Reset mid-row discards the pending half and the FIFO
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    row_len = 5'd4;
    send(16'h1234);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_vld", 32'(out_vld), 32'd0);
    chk("t6_rst_fill", 32'(fill_level), 32'd0);
    chk("t6_rst_in_rdy", 32'(in_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_in_rdy", 32'(in_rdy), 32'd1);
    for (int i = 5; i <= 8; i++) send(16'(i));
    pop_word("t6_w0", 32'h0006_0005, 1'b0);
    pop_word("t6_w1", 32'h0008_0007, 1'b1);
    chk("t6_empty_fill", 32'(fill_level), 32'd0);
    chk("t6_empty_data", out_data, 32'd0);
    chk("t6_rd_cnt", 32'(rd_cnt), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
